csr_trap_unit: RTL



---
 rtl/csr_trap_unit_pkg.sv | 33 +++
 rtl/csr_trap_unit_trap_fsm.sv | 61 ++++++
 rtl/csr_trap_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/csr_trap_unit_pkg.sv
// rtl/csr_trap_unit_pkg.sv - CSR addresses, bit positions and trap FSM state encoding
package csr_trap_unit_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    // Exception code of the machine external interrupt; the interrupt flag
    // (MSB) is added by the top where XLEN is known.
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    // Bit positions inside the status / enable / pending words
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;
    localparam int MIE_MEIE_BIT     = 11;
    localparam int MIP_MEIP_BIT     = 11;

    // Only machine mode exists, so MPP is hard-wired
    localparam logic [1:0] MPP_MACHINE = 2'b11;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } trap_state_e;

endpackage

// File: rtl/csr_trap_unit_trap_fsm.sv
// rtl/csr_trap_unit_trap_fsm.sv - trap sequencer: arbitration and pipeline control requests
module trap_fsm
    import csr_trap_unit_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_trap_req,
    input  logic i_irq_pending,
    input  logic i_mret,
    output logic o_take_exc,
    output logic o_take_irq,
    output logic o_take_mret,
    output logic o_pc_stall,
    output logic o_trap_flush,
    output logic o_redirect_valid
);

    trap_state_e state_q, state_d;

    // State register; reset abandons any redirect in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: exception > interrupt > mret; nothing is accepted while redirecting
    always_comb begin
        state_d          = state_q;
        o_take_exc       = 1'b0;
        o_take_irq       = 1'b0;
        o_take_mret      = 1'b0;
        o_pc_stall       = 1'b0;
        o_trap_flush     = 1'b0;
        o_redirect_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_trap_req) begin
                    o_take_exc = 1'b1;
                end else if (i_irq_pending) begin
                    o_take_irq = 1'b1;
                end else if (i_mret) begin
                    o_take_mret = 1'b1;
                end
                if (o_take_exc || o_take_irq) begin
                    o_pc_stall = 1'b1;
                    state_d    = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                o_trap_flush     = 1'b1;
                o_redirect_valid = 1'b1;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file with trap entry and mret state updates
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [11:0]     i_csr_addr_d,
    output logic [XLEN-1:0] o_csr_rdata_d,
    input  logic            i_csr_we_w,
    input  logic [11:0]     i_csr_addr_w,
    input  logic [XLEN-1:0] i_csr_wdata_w,
    input  logic            i_trap_req,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic [XLEN-1:0] i_trap_tval,
    input  logic            i_ext_irq,
    input  logic            i_mret_e,
    output logic [XLEN-1:0] o_mepc,
    output logic            o_pc_stall,
    output logic            o_trap_flush,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc
);

    // mtvec/mepc are word aligned: the two low bits never hold state
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] MCAUSE_MEI = {1'b1, (XLEN-1)'(CAUSE_MEI)};

    logic            mstatus_mie_q,  mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic            mie_meie_q,     mie_meie_d;
    logic [XLEN-1:0] mtvec_q,        mtvec_d;
    logic [XLEN-1:0] mscratch_q,     mscratch_d;
    logic [XLEN-1:0] mepc_q,         mepc_d;
    logic [XLEN-1:0] mcause_q,       mcause_d;
    logic [XLEN-1:0] mtval_q,        mtval_d;

    logic irq_pending;
    logic take_exc;
    logic take_irq;
    logic take_mret;
    logic bypass;

    // Architectural view of mstatus from its two live bits
    function automatic logic [XLEN-1:0] status_word(input logic mie, input logic mpie);
        logic [XLEN-1:0] w;
        w                                        = '0;
        w[MSTATUS_MIE_BIT]                       = mie;
        w[MSTATUS_MPIE_BIT]                      = mpie;
        w[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB]     = MPP_MACHINE;
        return w;
    endfunction

    assign irq_pending = mstatus_mie_q & mie_meie_q & i_ext_irq;

    trap_fsm u_trap_fsm (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_trap_req       (i_trap_req),
        .i_irq_pending    (irq_pending),
        .i_mret           (i_mret_e),
        .o_take_exc       (take_exc),
        .o_take_irq       (take_irq),
        .o_take_mret      (take_mret),
        .o_pc_stall       (o_pc_stall),
        .o_trap_flush     (o_trap_flush),
        .o_redirect_valid (o_redirect_valid)
    );

    // Next CSR state: WB write first, then trap/mret updates override it
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (i_csr_we_w) begin
            case (i_csr_addr_w)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = i_csr_wdata_w[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = i_csr_wdata_w[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_meie_d = i_csr_wdata_w[MIE_MEIE_BIT];
                CSR_MTVEC:    mtvec_d    = i_csr_wdata_w & ALIGN_MASK;
                CSR_MSCRATCH: mscratch_d = i_csr_wdata_w;
                CSR_MEPC:     mepc_d     = i_csr_wdata_w & ALIGN_MASK;
                CSR_MCAUSE:   mcause_d   = i_csr_wdata_w;
                CSR_MTVAL:    mtval_d    = i_csr_wdata_w;
                default: ;
            endcase
        end
        if (take_exc || take_irq) begin
            mepc_d         = i_trap_pc & ALIGN_MASK;
            mcause_d       = take_exc ? i_trap_cause : MCAUSE_MEI;
            mtval_d        = take_exc ? i_trap_tval : '0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (take_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    // CSR storage
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= XLEN'(RESET_MTVEC);
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    // ID read port; a same-cycle WB write to the same CSR is forwarded in masked form
    always_comb begin
        bypass        = i_csr_we_w && (i_csr_addr_w == i_csr_addr_d);
        o_csr_rdata_d = '0;
        case (i_csr_addr_d)
            CSR_MSTATUS:  o_csr_rdata_d = bypass
                              ? status_word(i_csr_wdata_w[MSTATUS_MIE_BIT], i_csr_wdata_w[MSTATUS_MPIE_BIT])
                              : status_word(mstatus_mie_q, mstatus_mpie_q);
            CSR_MIE:      o_csr_rdata_d[MIE_MEIE_BIT] = bypass ? i_csr_wdata_w[MIE_MEIE_BIT] : mie_meie_q;
            CSR_MIP:      o_csr_rdata_d[MIP_MEIP_BIT] = i_ext_irq;
            CSR_MTVEC:    o_csr_rdata_d = bypass ? (i_csr_wdata_w & ALIGN_MASK) : mtvec_q;
            CSR_MSCRATCH: o_csr_rdata_d = bypass ? i_csr_wdata_w : mscratch_q;
            CSR_MEPC:     o_csr_rdata_d = bypass ? (i_csr_wdata_w & ALIGN_MASK) : mepc_q;
            CSR_MCAUSE:   o_csr_rdata_d = bypass ? i_csr_wdata_w : mcause_q;
            CSR_MTVAL:    o_csr_rdata_d = bypass ? i_csr_wdata_w : mtval_q;
            default: ;
        endcase
    end

    assign o_mepc        = mepc_q;
    assign o_redirect_pc = mtvec_q;

endmodule
